lmsm_sequencer: RTL

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer.
// Ordinary instructions pass to the decoder one cycle after acceptance. A
// load-multiple (LM) or store-multiple (SM) is expanded into one LW or SW
// micro-op per set bit of its register list. The micro-ops are issued in
// ascending register order, one per non-stalled cycle. Each micro-op carries
// its transfer index in imm6. busy_out tells fetch to hold inst_in until the
// expansion is complete.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst_in,
  input  logic        stall_in,
  input  logic        flush,
  output logic [15:0] inst_out,
  output logic        busy_out,
  output logic        seq_active,
  output logic        seq_last
);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic [0:0]  state_q,      state_d;
  logic [7:0]  list_q,       list_d;
  logic [2:0]  count_q,      count_d;
  logic [2:0]  base_q,       base_d;
  logic        is_lm_q,      is_lm_d;
  logic [15:0] inst_out_q,   inst_out_d;
  logic        busy_q,       busy_d;
  logic        seq_active_q, seq_active_d;
  logic        seq_last_q,   seq_last_d;

  logic [3:0]  opcode;
  logic        is_multi;
  logic [7:0]  src_list;
  logic [2:0]  src_base;
  logic        src_lm;
  logic [2:0]  src_cnt;
  logic [2:0]  pick_idx;
  logic [7:0]  rem_list;
  logic [15:0] uop;

  assign opcode   = inst_in[15:12];
  assign is_multi = (opcode == OP_LM) || (opcode == OP_SM);

  // Returns the index of the lowest set bit; the result is don't-care for an all-zero list.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // The first micro-op is built directly from inst_in on the accepting edge.
  // Later micro-ops are built from the captured list and count.
  always_comb begin
    if (state_q == ST_SEQ) begin
      src_list = list_q;
      src_base = base_q;
      src_lm   = is_lm_q;
      src_cnt  = count_q;
    end else begin
      src_list = inst_in[7:0];
      src_base = inst_in[11:9];
      src_lm   = (opcode == OP_LM);
      src_cnt  = '0;
    end
    pick_idx = lowest_set(src_list);
    rem_list = src_list & ~(8'b1 << pick_idx);
    uop      = {(src_lm ? OP_LW : OP_SW), pick_idx, src_base, 3'b000, src_cnt};
  end

  // Next-state logic: flush beats stall, and stall holds everything.
  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    count_d      = count_q;
    base_d       = base_q;
    is_lm_d      = is_lm_q;
    inst_out_d   = inst_out_q;
    busy_d       = busy_q;
    seq_active_d = seq_active_q;
    seq_last_d   = seq_last_q;

    if (flush) begin
      state_d      = ST_PASS;
      list_d       = '0;
      count_d      = '0;
      inst_out_d   = '0;
      busy_d       = 1'b0;
      seq_active_d = 1'b0;
      seq_last_d   = 1'b0;
    end else if (!stall_in) begin
      if ((state_q == ST_PASS) && !is_multi) begin
        inst_out_d   = inst_in;
        seq_active_d = 1'b0;
        seq_last_d   = 1'b0;
        busy_d       = 1'b0;
      end else if ((state_q == ST_PASS) && (inst_in[7:0] == 8'h00)) begin
        // An empty register list degenerates to a bubble.
        inst_out_d   = '0;
        seq_active_d = 1'b0;
        seq_last_d   = 1'b0;
        busy_d       = 1'b0;
      end else begin
        inst_out_d   = uop;
        seq_active_d = 1'b1;
        base_d       = src_base;
        is_lm_d      = src_lm;
        list_d       = rem_list;
        count_d      = src_cnt + 3'd1;
        if (rem_list != 8'h00) begin
          state_d    = ST_SEQ;
          busy_d     = 1'b1;
          seq_last_d = 1'b0;
        end else begin
          state_d    = ST_PASS;
          busy_d     = 1'b0;
          seq_last_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PASS;
      list_q       <= '0;
      count_q      <= '0;
      base_q       <= '0;
      is_lm_q      <= 1'b0;
      inst_out_q   <= '0;
      busy_q       <= 1'b0;
      seq_active_q <= 1'b0;
      seq_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      count_q      <= count_d;
      base_q       <= base_d;
      is_lm_q      <= is_lm_d;
      inst_out_q   <= inst_out_d;
      busy_q       <= busy_d;
      seq_active_q <= seq_active_d;
      seq_last_q   <= seq_last_d;
    end
  end

  assign inst_out   = inst_out_q;
  assign busy_out   = busy_q;
  assign seq_active = seq_active_q;
  assign seq_last   = seq_last_q;

endmodule
